// File: rtl/tx_if.sv
// -----------------------------------------------------------------------------
// tx_if -- host-side write interface of the UART transmitter.
//
// Signals
//   i_data  WIDTH_DATA  word to send, sampled when i_we && o_rdy
//   i_we    1           write strobe, one i_clk cycle per word
//   o_rdy   1           1 = a write is accepted this cycle
//
// Modports
//   master  host / driver side (drives i_data, i_we; reads o_rdy)
//   slave   transmitter side (reads i_data, i_we; drives o_rdy)
// -----------------------------------------------------------------------------
interface tx_if #(
    parameter int WIDTH_DATA = 8
);
    logic [WIDTH_DATA-1:0] i_data;
    logic                  i_we;
    logic                  o_rdy;

    modport master (output i_data, output i_we, input  o_rdy);
    modport slave  (input  i_data, input  i_we, output o_rdy);
endinterface

// File: rtl/tx.sv
// -----------------------------------------------------------------------------
// tx -- UART transmitter, companion to the receiver.
//
// Frame: 1 start bit (0), WIDTH_DATA data bits LSB first, 1 stop bit (1).
// Bit timing comes from an external baud tick (clk_tx); only its rising edge,
// as seen in the i_clk domain, advances the frame. Each line level therefore
// lasts exactly one tick-edge-to-tick-edge interval.
//
// Parameters
//   WIDTH_DATA  data bits per frame, 1..13 (states live in a 4-bit counter:
//               data states 0..WIDTH_DATA-1 plus STOP, IDLE and START codes)
//
// Ports
//   i_clk       in   system clock
//   i_nrst      in   asynchronous active-low reset
//   clk_tx      in   baud tick from the baud generator (i_clk domain)
//   host        tx_if.slave: i_data / i_we in, o_rdy out
//   o_tx        out  serial line, registered, idle high
//   o_srst_clk  out  one-cycle sync restart request to the baud generator,
//                    raised when a write arrives in IDLE so that the start
//                    bit lasts a full bit period
//
// Build option
//   TX_BUF_EN   adds a one-word holding register in front of the shifter;
//               o_rdy then means "holding register empty" and queued words
//               follow the previous stop bit with no idle gap.
// -----------------------------------------------------------------------------
module tx #(
    parameter int WIDTH_DATA = 8
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic clk_tx,
    tx_if.slave  host,
    output logic o_tx,
    output logic o_srst_clk
);

    typedef enum logic [3:0] {
        S_DATA_0 = 4'd0,
        S_STOP   = 4'd13,
        S_IDLE   = 4'd14,
        S_START  = 4'd15
    } state_t;

    localparam logic [3:0] DATA_LAST = 4'(WIDTH_DATA - 1);

    state_t                state, state_d;
    logic [WIDTH_DATA-1:0] shift, shift_d, shift_nx;
    logic [WIDTH_DATA:0]   shift_ext;
    logic                  clk_tx_q;
    logic                  ev_pe;
    logic                  tx_d;
    logic                  rdy;
    logic                  accept;

    // Edge, not level: a tick held high for several cycles steps once.
    assign ev_pe     = clk_tx & ~clk_tx_q;

    // Shift right with ones filling from the top (works for WIDTH_DATA = 1).
    assign shift_ext = {1'b1, shift};
    assign shift_nx  = shift_ext[WIDTH_DATA:1];

`ifdef TX_BUF_EN
    logic [WIDTH_DATA-1:0] hold_data;
    logic                  hold_full, hold_full_d;
    logic                  hold_load;

    assign rdy = ~hold_full;
`else
    assign rdy = (state == S_IDLE);
`endif

    assign host.o_rdy = rdy;
    assign accept     = host.i_we & rdy;
    // Restart the baud generator only when a frame starts from idle; a tick
    // edge in this same cycle is ignored because IDLE only looks at accept.
    assign o_srst_clk = (state == S_IDLE) & host.i_we;

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        shift_d = shift;
        tx_d    = o_tx;
`ifdef TX_BUF_EN
        hold_full_d = hold_full;
        hold_load   = 1'b0;
        if (accept && (state != S_IDLE)) begin
            hold_load   = 1'b1;
            hold_full_d = 1'b1;
        end
`endif
        case (state)
            S_IDLE: begin
                if (accept) begin
                    shift_d = host.i_data;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (ev_pe) begin
                    state_d = S_DATA_0;
                    tx_d    = shift[0];
                end
            end
            S_STOP: begin
                if (ev_pe) begin
`ifdef TX_BUF_EN
                    // Chain the next word straight after the stop bit, keeping
                    // the tick phase. A word arriving in this very cycle with
                    // the holding register empty is taken directly, otherwise
                    // it would be parked in a register nobody drains in IDLE.
                    if (hold_full) begin
                        shift_d     = hold_data;
                        hold_full_d = 1'b0;
                        state_d     = S_START;
                        tx_d        = 1'b0;
                    end else if (accept) begin
                        shift_d     = host.i_data;
                        hold_load   = 1'b0;
                        hold_full_d = 1'b0;
                        state_d     = S_START;
                        tx_d        = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
`else
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
`endif
                end
            end
            default: begin // data states S_DATA_0 .. DATA_LAST
                if (ev_pe) begin
                    shift_d = shift_nx;
                    if (state == DATA_LAST) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        state_d = state_t'(state + 4'd1);
                        tx_d    = shift_nx[0];
                    end
                end
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // in this block samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state    <= S_IDLE;
            shift    <= '1;
            o_tx     <= 1'b1;
            clk_tx_q <= 1'b0;
`ifdef TX_BUF_EN
            hold_full <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            shift    <= shift_d;
            o_tx     <= tx_d;
            clk_tx_q <= clk_tx;
`ifdef TX_BUF_EN
            hold_full <= hold_full_d;
`endif
        end
    end

`ifdef TX_BUF_EN
    // NOTE: the holding data register has no reset; its content is only
    // used while hold_full is set, and hold_full itself is reset.
    always_ff @(posedge i_clk) begin
        if (hold_load) begin
            hold_data <= host.i_data;
        end
    end
`endif

endmodule

// File: tb/tb_tx.sv
// -----------------------------------------------------------------------------
// tb_tx -- self-checking bench for the UART transmitter tx.
//
// A free-running baud generator (16-cycle period, restartable by o_srst_clk,
// adjustable tick width) drives clk_tx. A queue-based line model predicts
// o_tx, o_rdy and o_srst_clk every cycle; directed frames are additionally
// pinned against hand-computed bit patterns.
// -----------------------------------------------------------------------------
module tb_tx;
    localparam int W = 8;

`ifdef TX_BUF_EN
    localparam bit HAS_BUF = 1'b1;
`else
    localparam bit HAS_BUF = 1'b0;
`endif

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    logic clk_tx = 1'b0;
    logic o_tx;
    logic o_srst_clk;

    tx_if #(.WIDTH_DATA(W)) host ();

    tx #(.WIDTH_DATA(W)) dut (
        .i_clk      (clk),
        .i_nrst     (nrst),
        .clk_tx     (clk_tx),
        .host       (host),
        .o_tx       (o_tx),
        .o_srst_clk (o_srst_clk)
    );

    always #5 clk = ~clk;

    // Baud generator: tick high for tick_w cycles every 16; restart puts the
    // first tick edge 16 cycles after the restart edge.
    logic [3:0] bcnt = 4'd0;
    int         tick_w = 1;
    always @(posedge clk) begin
        if (o_srst_clk) begin
            bcnt   <= 4'd0;
            clk_tx <= 1'b0;
        end else begin
            bcnt   <= bcnt + 4'd1;
            clk_tx <= (int'(4'(bcnt + 4'd2)) < tick_w);
        end
    end

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_srst = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Line model: current level, remaining levels of the frame in flight,
    // words waiting (holding register), previous tick level.
    // ------------------------------------------------------------------
    logic         m_tx   = 1'b1;
    bit           m_busy = 1'b0;
    bit           m_prev = 1'b0;
    bit           m_lv[$];
    logic [W-1:0] m_pend[$];

    function automatic void m_start(input logic [W-1:0] w);
        m_busy = 1'b1;
        m_tx   = 1'b0;
        m_lv.delete();
        for (int i = 0; i < W; i++) m_lv.push_back(w[i]);
        m_lv.push_back(1'b1);
    endfunction

    always @(negedge clk) begin : cmp
        bit   ev, acc, used;
        logic exp_rdy;
        #2;
        if (!nrst) begin
            m_busy = 1'b0;
            m_tx   = 1'b1;
            m_prev = 1'b0;
            m_lv.delete();
            m_pend.delete();
        end else begin
            exp_rdy = HAS_BUF ? (m_pend.size() == 0) : !m_busy;
            check("line", o_tx, m_tx);
            check("rdy", host.o_rdy, exp_rdy);
            check("srst", o_srst_clk, !m_busy && host.i_we);
            if (o_srst_clk === 1'b1) n_srst++;
            ev   = clk_tx && !m_prev;
            acc  = host.i_we && exp_rdy;
            used = 1'b0;
            if (!m_busy) begin
                if (acc) begin
                    m_start(host.i_data);
                    used = 1'b1;
                end
            end else if (ev) begin
                if (m_lv.size() != 0) m_tx = m_lv.pop_front();
                else if (m_pend.size() != 0) m_start(m_pend.pop_front());
                else if (HAS_BUF && acc) begin
                    m_start(host.i_data);
                    used = 1'b1;
                end else begin
                    m_busy = 1'b0;
                    m_tx   = 1'b1;
                end
            end
            if (HAS_BUF && acc && !used) m_pend.push_back(host.i_data);
            m_prev = clk_tx;
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    logic samp_tx   [0:320];
    logic samp_rdy  [0:320];
    logic samp_srst [0:320];

    // One-cycle write; returns at the first negedge after the accepting edge.
    task automatic write(input logic [W-1:0] w, output logic srst_seen);
        @(negedge clk);
        host.i_we   = 1'b1;
        host.i_data = w;
        #1 srst_seen = o_srst_clk;
        @(negedge clk);
        host.i_we   = 1'b0;
        host.i_data = W'($urandom);
    endtask

    // Record outputs for samples 0..n (sample k = k cycles after the write
    // edge); optionally issue one extra write at sample inject_at.
    task automatic capture(input int n, input int inject_at, input logic [W-1:0] inject_w);
        for (int s = 0; s <= n; s++) begin
            if (s > 0) @(negedge clk);
            if (s == inject_at) begin
                host.i_we   = 1'b1;
                host.i_data = inject_w;
            end else begin
                host.i_we = 1'b0;
            end
            #1;
            samp_tx[s]   = o_tx;
            samp_rdy[s]  = host.o_rdy;
            samp_srst[s] = o_srst_clk;
        end
        host.i_we = 1'b0;
    endtask

    task automatic check_levels(input string name, input int base, input logic [9:0] exp);
        for (int k = 0; k < 10; k++)
            check($sformatf("%s_bit%0d", name, k), samp_tx[base + 16*k + 8], exp[k]);
    endtask

    task automatic wait_rdy(input int budget);
        int k = 0;
        while (host.o_rdy !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k == budget) check("wait_rdy_timeout", host.o_rdy, 1);
    endtask

    initial begin
        logic       sr;
        int         srst0, ones;
        logic [9:0] exp_a5;
        host.i_we   = 1'b0;
        host.i_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_tx", o_tx, 1);
        check("rst_rdy", host.o_rdy, 1);
        @(negedge clk);
        nrst = 1'b1;

        // Idle: line high, ready, no restart request
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("idle_tx", o_tx, 1);
            check("idle_rdy", host.o_rdy, 1);
            check("idle_srst", o_srst_clk, 0);
        end

        // 0xA5: levels 0,1,0,1,0,0,1,0,1,1, 16 cycles each
        exp_a5 = 10'b1101001010;
        srst0  = n_srst;
        repeat (5) @(negedge clk);
        write(8'hA5, sr);
        check("a5_srst_at_write", sr, 1);
        capture(160, -1, '0);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("a5_first_%0d", k), samp_tx[16*k], exp_a5[k]);
            check($sformatf("a5_last_%0d", k), samp_tx[16*k + 15], exp_a5[k]);
        end
        check("a5_rdy_in_stop", samp_rdy[159], 0);
        check("a5_rdy_after", samp_rdy[160], 1);
        check("a5_idle_after", samp_tx[160], 1);
        ones = 0;
        for (int s = 0; s <= 160; s++) if (samp_srst[s] === 1'b1) ones++;
        check("a5_srst_in_frame", ones, 0);
        #2;
        check("a5_srst_pulses", n_srst - srst0, 1);

`ifndef TX_BUF_EN
        // 0x3C, then 0xFF during DATA_2 is dropped
        repeat (7) @(negedge clk);
        write(8'h3C, sr);
        capture(200, 50, 8'hFF);
        check("drop_rdy", samp_rdy[50], 0);
        check("drop_srst", samp_srst[50], 0);
        check_levels("f3c", 0, 10'b1001111000);
        check("drop_idle_170", samp_tx[170], 1);
        check("drop_idle_200", samp_tx[200], 1);
`else
        // 0x55 then 0x0F while busy: back to back, no idle gap
        repeat (7) @(negedge clk);
        write(8'h55, sr);
        capture(320, 20, 8'h0F);
        check("buf_rdy_20", samp_rdy[20], 1);
        check("buf_rdy_21", samp_rdy[21], 0);
        check("buf_rdy_159", samp_rdy[159], 0);
        check("buf_rdy_160", samp_rdy[160], 1);
        check("buf_stop_159", samp_tx[159], 1);
        check("buf_start_160", samp_tx[160], 0);
        check("buf_srst_20", samp_srst[20], 0);
        check_levels("f55", 0, 10'b1010101010);
        check_levels("f0f", 160, 10'b1000011110);
`endif

        // Reset in DATA_4 of 0x00, then a clean 0x81 frame
        wait_rdy(400);
        repeat (9) @(negedge clk);
        write(8'h00, sr);
        repeat (85) @(negedge clk);
        #1;
        check("mid_data4_low", o_tx, 0);
        nrst = 1'b0;
        #1;
        check("rst_mid_tx", o_tx, 1);
        check("rst_mid_rdy", host.o_rdy, 1);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        write(8'h81, sr);
        check("f81_srst", sr, 1);
        capture(160, -1, '0);
        check_levels("f81", 0, 10'b1100000010);

        // Random words, gaps, tick widths and extra writes while busy
        for (int i = 0; i < 256; i++) begin
            tick_w = int'($urandom_range(1, 3));
            repeat ($urandom_range(0, 12)) @(negedge clk);
            wait_rdy(400);
            write(W'($urandom), sr);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 150)) @(negedge clk);
                host.i_we   = 1'b1;
                host.i_data = W'($urandom);
                @(negedge clk);
                host.i_we   = 1'b0;
            end
        end
        tick_w = 1;
        repeat (400) @(negedge clk);
        #3;
        check("final_idle_tx", o_tx, 1);
        check("final_idle_rdy", host.o_rdy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
